// File: rtl/serial_adder_pkg.sv
// Shared definitions for serial_adder: FSM state encoding and bit-counter width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wide enough to count WIDTH-1 for the largest legal WIDTH (32).
    localparam int CNT_W = 5;

endpackage

// File: rtl/adder_1bit.sv
// One-bit full adder used by serial_adder for the per-bit sum and carry.
module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, one bit per clock, LSB first.
// Subtraction is enabled only when SERIAL_ADDER_SUB_EN is defined; otherwise sub is ignored.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             sub_r;
    logic             sub_eff;
    logic             fa_s;
    logic             fa_cout;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_eff = sub;
`else
    // Port kept for interface compatibility; add-only build never looks at it.
    logic sub_unused;
    assign sub_unused = sub;
    assign sub_eff    = 1'b0;
`endif

    assign dbg_state = state;

    // Subtraction feeds ~b with the carry preloaded to 1 (two's complement).
    adder_1bit u_fa (
        .a    (a_r[0]),
        .b    (b_r[0] ^ sub_r),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            cnt      <= '0;
            carry    <= 1'b0;
            sub_r    <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            acc      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        sub_r <= sub_eff;
                        carry <= sub_eff;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_r   <= a_r >> 1;
                    b_r   <= b_r >> 1;
                    carry <= fa_cout;
                    acc   <= {fa_s, acc[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    // Before this edge, carry holds the carry into the MSB.
                    if (cnt == LAST_BIT) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum      <= {fa_s, acc[WIDTH-1:1]};
                        cout     <= fa_cout;
                        overflow <= carry ^ fa_cout;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
